forney_poly_eval: RTL

Forney-stage operand generator for the RS(255,239) decoder, t = 8, GF(2^8) with primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D). For one error location it evaluates the error evaluator Ω(x) and the odd part of the locator Λodd(x) at a point x (Xk⁻¹ supplied by the Chien stage) using Horner's rule. It sits directly upstream of the Forney GF multiplier. `num_out` and `den_out` feed that multiplier's `a`/`b` paths (`den_out` goes via the inverter), and `coef_ready_flag` drives its `coef_ready_flag` input.

---
 rtl/rs_gf_pkg.sv | 20 ++
 rtl/gf_mult_comb.sv | 29 ++
 rtl/forney_poly_eval.sv | 139 +++++++++++++
 3 files changed

// File: rtl/rs_gf_pkg.sv
// Shared GF(2^8) definitions for the RS(255,239) decoder datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: field width, primitive polynomial 0x11D, correction capability,
// the symbol type and the Forney operand-generator state encoding.
package rs_gf_pkg;

  localparam int          GF_M    = 8;
  localparam logic [8:0]  GF_PRIM = 9'h11D;
  localparam int          RS_T    = 8;

  typedef logic [GF_M-1:0] gf_sym_t;

  typedef enum logic [1:0] {
    FPE_IDLE = 2'd0,
    FPE_EVAL = 2'd1,
    FPE_DONE = 2'd2
  } fpe_state_t;

endpackage

// File: rtl/gf_mult_comb.sv
// Purely combinational GF(2^8) polynomial-basis multiply, p = a*b mod 0x11D.
// Latency: 0 cycles (combinational).
// Backpressure: none; output follows inputs.
// Ports: a, b - operand symbols; p - product symbol.
module gf_mult_comb
  import rs_gf_pkg::*;
(
  input  gf_sym_t a,
  input  gf_sym_t b,
  output gf_sym_t p
);

  gf_sym_t acc;
  gf_sym_t sh;

  // Shift-and-add: sh walks through a*x^i (reduced each step), and is
  // accumulated wherever the matching bit of b is set.
  always_comb begin
    acc = '0;
    sh  = a;
    for (int i = 0; i < GF_M; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[GF_M-2:0], 1'b0} ^ (sh[GF_M-1] ? GF_PRIM[GF_M-1:0] : gf_sym_t'(0));
    end
  end

  assign p = acc;

endmodule

// File: rtl/forney_poly_eval.sv
// Forney operand generator: Horner evaluation of Omega(x) and Lambda_odd(x).
// Latency: 8 cycles from accepted start to coef_ready_flag.
// Backpressure: start accepted only in IDLE/DONE; results held until next accept.
// Ports: clock/reset (async, active-high); start, x_in, omega_in, lambda_odd_in
// in; busy, num_out, den_out, den_zero, coef_ready_flag out (all registered).
module forney_poly_eval
  import rs_gf_pkg::*;
#(
  parameter int T = RS_T,
  parameter int M = GF_M
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [M-1:0]       x_in,
  input  logic [T*M-1:0]     omega_in,
  input  logic [T/2*M-1:0]   lambda_odd_in,
  output logic               busy,
  output logic [M-1:0]       num_out,
  output logic [M-1:0]       den_out,
  output logic               den_zero,
  output logic               coef_ready_flag
);

  localparam int IDXW = $clog2(T);

  fpe_state_t       state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [M-1:0]     x_q, x_d;
  logic [T*M-1:0]   omega_q, omega_d;
  logic [T/2*M-1:0] lambda_q, lambda_d;
  logic [M-1:0]     acc_n_q, acc_n_d;
  logic [M-1:0]     acc_d_q, acc_d_d;
  logic [M-1:0]     num_q, num_d;
  logic [M-1:0]     den_q, den_d;
  logic             den_zero_q, den_zero_d;
  logic             busy_q, busy_d;
  logic             rdy_q, rdy_d;

  logic [M-1:0]     omega_coef;
  logic [M-1:0]     lambda_coef;
  gf_sym_t          prod_n;
  gf_sym_t          prod_d;

  gf_mult_comb u_mult_n (.a(acc_n_q), .b(x_q), .p(prod_n));
  gf_mult_comb u_mult_d (.a(acc_d_q), .b(x_q), .p(prod_d));

  // Omega uses every coefficient; the locator path only carries odd powers,
  // and lambda byte j holds the coefficient of x^(2j+1).
  always_comb begin
    omega_coef  = omega_q[int'(idx_q)*M +: M];
    lambda_coef = idx_q[0] ? lambda_q[int'(idx_q >> 1)*M +: M] : '0;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    x_d        = x_q;
    omega_d    = omega_q;
    lambda_d   = lambda_q;
    acc_n_d    = acc_n_q;
    acc_d_d    = acc_d_q;
    num_d      = num_q;
    den_d      = den_q;
    den_zero_d = den_zero_q;
    busy_d     = busy_q;
    rdy_d      = rdy_q;

    case (state_q)
      FPE_IDLE, FPE_DONE: begin
        if (start) begin
          state_d  = FPE_EVAL;
          x_d      = x_in;
          omega_d  = omega_in;
          lambda_d = lambda_odd_in;
          acc_n_d  = '0;
          acc_d_d  = '0;
          idx_d    = IDXW'(T-1);
          busy_d   = 1'b1;
          rdy_d    = 1'b0;
        end
      end
      FPE_EVAL: begin
        acc_n_d = prod_n ^ omega_coef;
        acc_d_d = prod_d ^ lambda_coef;
        idx_d   = idx_q - IDXW'(1);
        if (idx_q == '0) begin
          // Final Horner step: publish into the hold registers so the
          // downstream multiplier sees stable operands until next accept.
          state_d    = FPE_DONE;
          idx_d      = IDXW'(T-1);
          num_d      = acc_n_d;
          den_d      = acc_d_d;
          den_zero_d = (acc_d_d == '0);
          busy_d     = 1'b0;
          rdy_d      = 1'b1;
        end
      end
      default: state_d = FPE_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= FPE_IDLE;
      idx_q      <= IDXW'(T-1);
      x_q        <= '0;
      omega_q    <= '0;
      lambda_q   <= '0;
      acc_n_q    <= '0;
      acc_d_q    <= '0;
      num_q      <= '0;
      den_q      <= '0;
      den_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      x_q        <= x_d;
      omega_q    <= omega_d;
      lambda_q   <= lambda_d;
      acc_n_q    <= acc_n_d;
      acc_d_q    <= acc_d_d;
      num_q      <= num_d;
      den_q      <= den_d;
      den_zero_q <= den_zero_d;
      busy_q     <= busy_d;
      rdy_q      <= rdy_d;
    end
  end

  assign busy            = busy_q;
  assign num_out         = num_q;
  assign den_out         = den_q;
  assign den_zero        = den_zero_q;
  assign coef_ready_flag = rdy_q;

endmodule
